// File: rtl/dcache_sram_nway.sv
// N-way set-associative data cache storage: tag/data arrays, true-LRU ages and
// an invalidate-all sweep. Lookup and way selection are combinational.
module dcache_sram_nway_way #(
  parameter int TAG_W = 23
) (
  input  logic             valid_i,
  input  logic [TAG_W-1:0] stored_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             hit_o
);
  assign hit_o = valid_i && (stored_i == tag_i);
endmodule

module dcache_sram_nway #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4,
  parameter int TAG_W    = 23,
  parameter int LINE_W   = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [$clog2(NUM_SETS)-1:0] addr_i,
  input  logic [TAG_W+1:0]            tag_i,
  input  logic [LINE_W-1:0]           data_i,
  input  logic                        enable_i,
  input  logic                        write_i,
  input  logic                        inv_i,
  output logic [TAG_W+1:0]            tag_o,
  output logic [LINE_W-1:0]           data_o,
  output logic                        hit_o,
  output logic [$clog2(NUM_WAYS)-1:0] way_o,
  output logic                        busy_o
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);

  typedef enum logic {S_IDLE, S_INV} state_e;

  state_e                                state_q, state_d;
  logic [IDX_W-1:0]                      cnt_q, cnt_d;

  logic [NUM_WAYS-1:0]                   valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]                   dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0][TAG_W-1:0]        tag_q   [NUM_SETS];
  logic [NUM_WAYS-1:0][LINE_W-1:0]       data_q  [NUM_SETS];
  logic [NUM_WAYS-1:0][WAY_W-1:0]        age_q   [NUM_SETS];

  logic [NUM_WAYS-1:0]                   set_valid, set_dirty, hit_vec;
  logic [NUM_WAYS-1:0][TAG_W-1:0]        set_tag;
  logic [NUM_WAYS-1:0][WAY_W-1:0]        set_age;
  logic [WAY_W-1:0]                      sel_way, old_age;
  logic                                  any_hit, access, touch;
  logic                                  unused_valid;

  // The incoming valid bit is not stored: a write always marks the way valid.
  assign unused_valid = tag_i[TAG_W+1];

  assign set_valid = valid_q[addr_i];
  assign set_dirty = dirty_q[addr_i];
  assign set_tag   = tag_q[addr_i];
  assign set_age   = age_q[addr_i];

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    dcache_sram_nway_way #(.TAG_W(TAG_W)) u_cmp (
      .valid_i  (set_valid[w]),
      .stored_i (set_tag[w]),
      .tag_i    (tag_i[TAG_W-1:0]),
      .hit_o    (hit_vec[w])
    );
  end

  assign any_hit = |hit_vec;
  assign busy_o  = (state_q == S_INV);
  assign access  = enable_i && (state_q == S_IDLE);
  assign touch   = access && (write_i || any_hit);

  // Priority: lowest hit, then lowest invalid, then the LRU victim.
  always_comb begin
    logic found;
    found   = 1'b0;
    sel_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && hit_vec[w]) begin
        sel_way = WAY_W'(w);
        found   = 1'b1;
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && !set_valid[w]) begin
        sel_way = WAY_W'(w);
        found   = 1'b1;
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && set_age[w] == WAY_W'(NUM_WAYS-1)) begin
        sel_way = WAY_W'(w);
        found   = 1'b1;
      end
    end
  end

  assign old_age = set_age[sel_way];
  assign way_o   = sel_way;
  assign hit_o   = any_hit && !busy_o;
  assign tag_o   = {set_valid[sel_way], set_dirty[sel_way], set_tag[sel_way]};
  assign data_o  = data_q[addr_i][sel_way];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (inv_i) begin
          state_d = S_INV;
          cnt_d   = '0;
        end
      end
      S_INV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(NUM_SETS-1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        tag_q[s]   <= '0;
        data_q[s]  <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else if (state_q == S_INV) begin
      // Sweep leaves tags and data in place; only state bits are cleared.
      valid_q[cnt_q] <= '0;
      dirty_q[cnt_q] <= '0;
      for (int w = 0; w < NUM_WAYS; w++) age_q[cnt_q][w] <= WAY_W'(w);
    end else begin
      if (access && write_i) begin
        data_q[addr_i][sel_way]  <= data_i;
        tag_q[addr_i][sel_way]   <= tag_i[TAG_W-1:0];
        valid_q[addr_i][sel_way] <= 1'b1;
        dirty_q[addr_i][sel_way] <= tag_i[TAG_W];
      end
      if (touch) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (sel_way == WAY_W'(w))
            age_q[addr_i][w] <= '0;
          else if (set_age[w] < old_age)
            age_q[addr_i][w] <= set_age[w] + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed bench for dcache_sram_nway: expectations queued at drive time and
// popped against DUT outputs once they settle.
module tb_dcache_sram_nway;
  localparam int NS = 16;
  localparam int NW = 4;
  localparam int TW = 23;
  localparam int LW = 256;
  localparam int IW = 4;
  localparam int WW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] addr;
  logic [TW+1:0] tag;
  logic [LW-1:0] data;
  logic          en, wr, inv;
  logic [TW+1:0] tag_o;
  logic [LW-1:0] data_o;
  logic          hit_o, busy_o;
  logic [WW-1:0] way_o;

  always #5 clk = ~clk;

  dcache_sram_nway #(.NUM_SETS(NS), .NUM_WAYS(NW), .TAG_W(TW), .LINE_W(LW)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .tag_i(tag), .data_i(data),
    .enable_i(en), .write_i(wr), .inv_i(inv), .tag_o(tag_o), .data_o(data_o),
    .hit_o(hit_o), .way_o(way_o), .busy_o(busy_o)
  );

  typedef struct { string name; logic [LW-1:0] exp; } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [TW+1:0] tg(input bit v, input bit d, input int t);
    return {v, d, t[TW-1:0]};
  endfunction

  function automatic logic [LW-1:0] line(input int t);
    logic [31:0] w;
    w = 32'hA5A50000 ^ t;
    return {8{w}};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int a, input logic [TW+1:0] t, input logic [LW-1:0] d,
                     input bit e, input bit w, input bit i);
    addr = a[IW-1:0];
    tag  = t;
    data = d;
    en   = e;
    wr   = w;
    inv  = i;
  endtask

  task automatic put(input string n, input logic [LW-1:0] v);
    exp_t e;
    e.name = n;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic got(input logic [LW-1:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %0h, nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic look(input string n, input bit h, input int wy, input logic [TW+1:0] t);
    put({n, ".hit"}, LW'(h));
    put({n, ".way"}, LW'(wy));
    put({n, ".tag"}, LW'(t));
    #1;
    got(LW'(hit_o));
    got(LW'(way_o));
    got(LW'(tag_o));
  endtask

  task automatic chkv(input string n, input logic [LW-1:0] e, input logic [LW-1:0] obs);
    put(n, e);
    got(obs);
  endtask

  initial begin
    int cyc;
    // reset with a write request held: reset must win
    rst = 1'b1;
    drv(12, tg(1, 0, 'hC0), line('hC0), 1, 1, 0);
    step;
    step;
    rst = 1'b0;
    drv(3, tg(1, 0, 'h10), line(1), 0, 0, 0);
    look("rst", 0, 0, '0);
    chkv("rst.data", '0, data_o);
    chkv("rst.busy", '0, LW'(busy_o));
    drv(12, tg(1, 0, 'hC0), '0, 0, 0, 0);
    look("rst_prio", 0, 0, '0);

    // fill set 3 in way order
    for (int i = 0; i < 4; i++) begin
      drv(3, tg(1, 0, 'h10 + i), line('h10 + i), 1, 1, 0);
      look($sformatf("fill%0d", i), 0, i, '0);
      step;
    end
    drv(3, tg(1, 0, 'h12), '0, 1, 0, 0);
    look("rd12", 1, 2, tg(1, 0, 'h12));
    chkv("rd12.data", line('h12), data_o);
    step;

    // LRU replacement
    drv(3, tg(1, 0, 'h10), '0, 1, 0, 0);
    look("rd10", 1, 0, tg(1, 0, 'h10));
    step;
    drv(3, tg(1, 0, 'h14), line('h14), 1, 1, 0);
    look("wr14", 0, 1, tg(1, 0, 'h11));
    step;
    drv(3, tg(1, 0, 'h11), '0, 1, 0, 0);
    look("rd11", 0, 3, tg(1, 0, 'h13));
    step;
    drv(3, tg(1, 0, 'h14), '0, 0, 0, 0);
    look("rd14", 1, 1, tg(1, 0, 'h14));
    chkv("rd14.data", line('h14), data_o);

    // dirty write hit, then age way 2 to LRU and read a miss
    drv(3, tg(1, 1, 'h12), line('h92), 1, 1, 0);
    look("wd12", 1, 2, tg(1, 0, 'h12));
    step;
    drv(3, tg(1, 0, 'h12), '0, 0, 0, 0);
    look("dirty12", 1, 2, tg(1, 1, 'h12));
    chkv("dirty12.data", line('h92), data_o);
    drv(3, tg(1, 0, 'h10), '0, 1, 0, 0);
    look("age10", 1, 0, tg(1, 0, 'h10));
    step;
    drv(3, tg(1, 0, 'h14), '0, 1, 0, 0);
    look("age14", 1, 1, tg(1, 0, 'h14));
    step;
    drv(3, tg(1, 0, 'h13), '0, 1, 0, 0);
    look("age13", 1, 3, tg(1, 0, 'h13));
    step;
    drv(3, tg(1, 0, 'h99), '0, 1, 0, 0);
    look("victim", 0, 2, tg(1, 1, 'h12));
    step;

    // invalidate sweep; writes and inv requests during it are ignored
    drv(0, '0, '0, 0, 0, 1);
    step;
    for (int k = 0; k < 16; k++) begin
      if (k == 0) begin
        drv(3, tg(1, 0, 'h10), '0, 0, 0, 0);
        look("inv_gate", 0, 0, tg(1, 0, 'h10));
      end else begin
        drv(5, tg(1, 0, 'h77), line('h77), 1, 1, k == 15);
        #1;
      end
      chkv($sformatf("inv_busy%0d", k), LW'(1), LW'(busy_o));
      step;
    end
    drv(3, tg(1, 0, 'h10), '0, 0, 0, 0);
    look("postinv3", 0, 0, tg(0, 0, 'h10));
    chkv("postinv.busy", '0, LW'(busy_o));
    chkv("postinv3.data", line('h10), data_o);
    drv(5, tg(1, 0, 'h77), '0, 0, 0, 0);
    look("postinv5", 0, 0, '0);

    // simultaneous write + invalidate
    drv(7, tg(1, 0, 'h55), line('h55), 1, 1, 1);
    look("simul", 0, 0, '0);
    chkv("simul.busy0", '0, LW'(busy_o));
    step;
    drv(7, tg(1, 0, 'h55), '0, 0, 0, 0);
    look("simul_land", 0, 0, tg(1, 0, 'h55));
    chkv("simul.busy1", LW'(1), LW'(busy_o));
    cyc = 1;
    while (busy_o && cyc < 40) begin
      step;
      cyc++;
    end
    chkv("simul.len", LW'(16), LW'(cyc - 1));
    look("simul_post", 0, 0, tg(0, 0, 'h55));
    chkv("simul_post.data", line('h55), data_o);

    // reset in the middle of a sweep
    drv(12, tg(1, 0, 'hA0), line('hA0), 1, 1, 0);
    look("pre_a0", 0, 0, '0);
    step;
    drv(12, tg(1, 0, 'hA1), line('hA1), 1, 1, 0);
    look("pre_a1", 0, 1, '0);
    step;
    drv(12, '0, '0, 0, 0, 1);
    step;
    drv(12, '0, '0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step;
    chkv("mid.busy", LW'(1), LW'(busy_o));
    drv(12, tg(1, 0, 'hC1), line('hC1), 1, 1, 1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    drv(12, tg(1, 0, 'hA0), '0, 0, 0, 0);
    look("rstmid12", 0, 0, '0);
    chkv("rstmid.busy", '0, LW'(busy_o));
    chkv("rstmid.data", '0, data_o);
    drv(7, tg(1, 0, 'h55), '0, 0, 0, 0);
    look("rstmid7", 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      drv(12, tg(1, 0, 'hB0 + i), line('hB0 + i), 1, 1, 0);
      look($sformatf("refill%0d", i), 0, i, '0);
      step;
    end
    drv(12, tg(1, 0, 'hB9), line('hB9), 1, 1, 0);
    look("refill_victim", 0, 0, tg(1, 0, 'hB0));
    step;
    drv(12, tg(1, 0, 'hB9), '0, 0, 0, 0);
    look("refill_b9", 1, 0, tg(1, 0, 'hB9));
    chkv("refill_b9.data", line('hB9), data_o);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
